// File: rtl/rr_slice_arbiter.sv
// rr_slice_arbiter
//   Round-robin arbiter with time slicing. An owner keeps its grant for up
//   to SLICE cycles while it keeps requesting. When the slice runs out, or
//   the owner drops its request, the arbiter re-arbitrates starting one
//   index above the owner. Handover is direct from one owner to the next,
//   with no idle cycle in between.
//
//   Optional feature: define RR_ARB_LOCK_EN to add a 'lock' input. When
//   lock is high at slice expiry and the owner is still requesting, the
//   owner keeps the grant and slice_end stays high.
//
// Parameters
//   N      number of requesters (1..16)
//   SLICE  maximum grant length in cycles (1..255)
//   IDW    width of gnt_id
// Ports
//   c          clock, rising edge
//   r          synchronous active-high reset
//   lock       (RR_ARB_LOCK_EN only) hold the owner past slice expiry
//   req        request vector, one bit per requester
//   gnt        registered one-hot grant, or zero
//   gnt_vld    registered, high when any gnt bit is high
//   gnt_id     registered owner index, 0 when idle
//   slice_end  registered, high in the last cycle of a full slice
module rr_slice_arbiter #(
    parameter int N     = 4,
    parameter int SLICE = 4,
    parameter int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           c,
    input  logic           r,
`ifdef RR_ARB_LOCK_EN
    input  logic           lock,
`endif
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           slice_end
);
    localparam int            CW   = $clog2(SLICE + 1);
    localparam logic [CW-1:0] CMAX = CW'(SLICE - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         r_state, w_state;
    logic [IDW-1:0] r_owner, w_owner;
    logic [IDW-1:0] r_ptr,   w_ptr;
    logic [CW-1:0]  r_cnt,   w_cnt;
    logic [N-1:0]   r_gnt,   w_gnt;
    logic           r_vld,   w_vld;
    logic           r_se,    w_se;

    logic [N-1:0]   w_own_oh;
    logic           w_own_req;
    logic [IDW:0]   w_pick_all;   // {found, index}
    logic [IDW:0]   w_pick_oth;   // same search with the current owner masked
    logic           w_lock;

`ifdef RR_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // First set bit of v at or above p, wrapping modulo N. The loop runs
    // from the far end down so the nearest hit is the last one written.
    function automatic logic [IDW:0] f_pick(input logic [N-1:0] v,
                                            input logic [IDW-1:0] p);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N;
            if (v[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] x);
        return IDW'((int'(x) + 1) % N);
    endfunction

    assign w_own_oh   = N'(1) << r_owner;
    assign w_own_req  = |(req & w_own_oh);
    assign w_pick_all = f_pick(req, r_ptr);
    assign w_pick_oth = f_pick(req & ~w_own_oh, r_ptr);

    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_all[IDW]) begin
                    w_state = GRANT;
                    w_owner = w_pick_all[IDW-1:0];
                    w_ptr   = f_inc(w_pick_all[IDW-1:0]);
                    w_cnt   = '0;
                end
            end
            GRANT: begin
                if (w_own_req) begin
                    if (r_cnt != CMAX) begin
                        w_cnt = r_cnt + CW'(1);
                    end else if (w_lock) begin
                        w_cnt = r_cnt;          // expiry suppressed
                    end else if (w_pick_oth[IDW]) begin
                        w_owner = w_pick_oth[IDW-1:0];
                        w_ptr   = f_inc(w_pick_oth[IDW-1:0]);
                        w_cnt   = '0;
                    end else begin
                        // sole requester: fresh slice, ptr already owner+1
                        w_cnt = '0;
                    end
                end else if (w_pick_all[IDW]) begin
                    w_owner = w_pick_all[IDW-1:0];
                    w_ptr   = f_inc(w_pick_all[IDW-1:0]);
                    w_cnt   = '0;
                end else begin
                    w_state = IDLE;
                    w_owner = '0;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = IDLE;
                w_owner = '0;
                w_cnt   = '0;
            end
        endcase
        w_vld = (w_state == GRANT);
        w_gnt = w_vld ? (N'(1) << w_owner) : '0;
        w_se  = w_vld && (w_cnt == CMAX);
    end

    always_ff @(posedge c) begin
        if (r) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
            r_se    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_gnt   <= w_gnt;
            r_vld   <= w_vld;
            r_se    <= w_se;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_vld   = r_vld;
    assign gnt_id    = r_owner;
    assign slice_end = r_se;
endmodule

// File: tb/tb_rr_slice_arbiter.sv
module tb_rr_slice_arbiter;
    localparam int N     = 4;
    localparam int SLICE = 4;
    localparam int IDW   = 2;

    logic           c = 1'b0;
    logic           r;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic           slice_end;
`ifdef RR_ARB_LOCK_EN
    logic           lock;
`endif

    rr_slice_arbiter #(.N(N), .SLICE(SLICE), .IDW(IDW)) dut (
        .c         (c),
        .r         (r),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .gnt       (gnt),
        .gnt_vld   (gnt_vld),
        .gnt_id    (gnt_id),
        .slice_end (slice_end)
    );

    always #5 c = ~c;

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic       lk;
        logic [3:0] eg;   // expected gnt after the edge
        logic       es;   // expected slice_end after the edge
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic [3:0] rq, input logic lk,
                       input logic [3:0] eg, input logic es);
        vec_t v;
        v.rst = rst; v.rq = rq; v.lk = lk; v.eg = eg; v.es = es;
        tbl.push_back(v);
    endtask

    // n cycles of the same grant with constant inputs; slice_end on
    // the listed cycle positions of a fresh slice (every SLICE-th).
    task automatic add_run(input logic [3:0] rq, input logic [3:0] eg, input int n);
        for (int k = 1; k <= n; k++) add(1'b0, rq, 1'b0, eg, (k % SLICE) == 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int res;
        res = 0;
        for (int k = 0; k < 4; k++) if (g[k]) res = k;
        return res;
    endfunction

    logic [N-1:0] prev_req;
    vec_t         e;

    initial begin
        r   = 1'b1;
        req = '0;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif
        repeat (2) @(posedge c);

        // reset with all requesting, then full rotation
        add(1'b1, 4'hF, 1'b0, 4'b0000, 1'b0);
        add(1'b1, 4'hF, 1'b0, 4'b0000, 1'b0);
        add_run(4'hF, 4'b0001, 4);
        add_run(4'hF, 4'b0010, 4);
        add_run(4'hF, 4'b0100, 4);
        add_run(4'hF, 4'b1000, 4);
        add(1'b0, 4'hF, 1'b0, 4'b0001, 1'b0);
        // sole requester renews without a gap, then release -> idle
        add(1'b1, 4'h0, 1'b0, 4'b0000, 1'b0);
        add_run(4'b0100, 4'b0100, 10);
        add(1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
        // early release: owner 1 drops at cycle 2, next owner is 3 not 0
        add(1'b1, 4'h0, 1'b0, 4'b0000, 1'b0);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0);
        add_run(4'b1001, 4'b1000, 4);
        add(1'b0, 4'b1001, 1'b0, 4'b0001, 1'b0);   // wrap to 0 after expiry
        // reset mid-slice revokes, restart from index 0
        add(1'b1, 4'h0, 1'b0, 4'b0000, 1'b0);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0);
        add(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0);
        add(1'b0, 4'b1001, 1'b0, 4'b0001, 1'b0);
`ifdef RR_ARB_LOCK_EN
        // lock holds owner 0 past expiry; one edge after lock falls -> 1
        add(1'b1, 4'h0, 1'b0, 4'b0000, 1'b0);
        for (int k = 1; k <= 7; k++) add(1'b0, 4'hF, 1'b1, 4'b0001, k >= 4);
        add(1'b0, 4'hF, 1'b0, 4'b0010, 1'b0);
`endif

        foreach (tbl[i]) begin
            @(negedge c);
            r   = tbl[i].rst;
            req = tbl[i].rq;
`ifdef RR_ARB_LOCK_EN
            lock = tbl[i].lk;
`endif
            sb.push_back(tbl[i]);
            @(posedge c);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_gnt", i), int'(gnt), int'(e.eg));
            chk($sformatf("v%0d_vld", i), int'(gnt_vld), int'(|e.eg));
            chk($sformatf("v%0d_id", i), int'(gnt_id), idx_of(e.eg));
            chk($sformatf("v%0d_se", i), int'(slice_end), int'(e.es));
        end

        // random traffic: structural properties of every grant
        @(negedge c);
        r   = 1'b1;
        req = '0;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif
        @(negedge c);
        r = 1'b0;
        for (int i = 0; i < 300; i++) begin
            req      = 4'($urandom_range(0, 15));
            prev_req = req;
            @(posedge c);
            #1;
            chk("rnd_onehot", int'((gnt & (gnt - 4'd1)) == 4'd0), 1);
            chk("rnd_vld_any_req", int'(gnt_vld), int'(|prev_req));
            chk("rnd_owner_requested", int'((gnt & prev_req) == gnt), 1);
            chk("rnd_id", int'(gnt_id), idx_of(gnt));
            @(negedge c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
